// File: rtl/snake_pkg.sv
// Shared types for the snake head stepper: headings, FSM states, reversal helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_RIGHT = 2'b10,
        DIR_LEFT  = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    function automatic dir_t opposite(input dir_t d);
        dir_t r;
        r = DIR_DOWN;
        case (d)
            DIR_UP:    r = DIR_DOWN;
            DIR_DOWN:  r = DIR_UP;
            DIR_RIGHT: r = DIR_LEFT;
            DIR_LEFT:  r = DIR_RIGHT;
            default:   r = DIR_DOWN;
        endcase
        return r;
    endfunction

    // A snake may not fold back onto itself in a single step.
    function automatic logic is_reversal(input dir_t cur, input dir_t req);
        return (req == opposite(cur));
    endfunction

endpackage

// File: rtl/snake_tick_gen.sv
// Step-rate divider: raises tick on every TICK_DIV-th enabled cycle.
// Latency: tick is combinational from the count; count advances one per enabled cycle.
// Backpressure: en low freezes the count; clr zeroes it and masks tick that cycle.
module snake_tick_gen #(
    parameter int TICK_DIV = 5_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] cnt;

    assign tick = en && !clr && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + ONE;
        end
    end

endmodule

// File: rtl/snake_head_step.sv
// Snake head position stepper with IDLE/RUN/OVER control; SNAKE_WRAP_EN makes walls wrap.
// Latency: head/heading/move_pulse update on the tick edge; game_over rises the cycle after a wall hit.
// Backpressure: pause freezes the step counter in RUN; start always restarts from centre.
module snake_head_step #(
    parameter int GRID_W   = 32,
    parameter int GRID_H   = 24,
    parameter int TICK_DIV = 5_000_000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      pause,
    input  logic [1:0]                direction,
    output logic [$clog2(GRID_W)-1:0] head_x,
    output logic [$clog2(GRID_H)-1:0] head_y,
    output logic                      move_pulse,
    output logic                      game_over,
    output logic [1:0]                heading
);

    import snake_pkg::*;

    localparam int XW = $clog2(GRID_W);
    localparam int YW = $clog2(GRID_H);

    localparam logic [XW-1:0] X_MID = XW'(GRID_W / 2);
    localparam logic [XW-1:0] X_MAX = XW'(GRID_W - 1);
    localparam logic [XW-1:0] X_ONE = XW'(1);
    localparam logic [YW-1:0] Y_MID = YW'(GRID_H / 2);
    localparam logic [YW-1:0] Y_MAX = YW'(GRID_H - 1);
    localparam logic [YW-1:0] Y_ONE = YW'(1);

`ifdef SNAKE_WRAP_EN
    localparam logic WRAP_EN = 1'b1;
`else
    localparam logic WRAP_EN = 1'b0;
`endif

    state_t        state_q;
    state_t        state_d;
    dir_t          heading_q;
    dir_t          step_dir;
    logic [XW-1:0] x_q;
    logic [XW-1:0] x_step;
    logic [YW-1:0] y_q;
    logic [YW-1:0] y_step;
    logic          pulse_q;
    logic          tick;
    logic          tick_en;
    logic          tick_clr;
    logic          hit_wall;
    logic          move_ok;
    logic          wall_over;

    assign tick_en  = (state_q == ST_RUN) && !pause;
    assign tick_clr = start || (state_q != ST_RUN);

    snake_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (tick_en),
        .clr   (tick_clr),
        .tick  (tick)
    );

    always_comb begin
        step_dir = dir_t'(direction);
        if (is_reversal(heading_q, dir_t'(direction))) begin
            step_dir = heading_q;
        end
    end

    // Candidate position; at a wall it is the wrapped cell, used only when wrapping is enabled.
    always_comb begin
        x_step   = x_q;
        y_step   = y_q;
        hit_wall = 1'b0;
        case (step_dir)
            DIR_UP: begin
                if (y_q == '0) begin
                    hit_wall = 1'b1;
                    y_step   = Y_MAX;
                end else begin
                    y_step = y_q - Y_ONE;
                end
            end
            DIR_DOWN: begin
                if (y_q == Y_MAX) begin
                    hit_wall = 1'b1;
                    y_step   = '0;
                end else begin
                    y_step = y_q + Y_ONE;
                end
            end
            DIR_RIGHT: begin
                if (x_q == X_MAX) begin
                    hit_wall = 1'b1;
                    x_step   = '0;
                end else begin
                    x_step = x_q + X_ONE;
                end
            end
            DIR_LEFT: begin
                if (x_q == '0) begin
                    hit_wall = 1'b1;
                    x_step   = X_MAX;
                end else begin
                    x_step = x_q - X_ONE;
                end
            end
            default: begin
                x_step = x_q;
            end
        endcase
    end

    assign move_ok   = WRAP_EN || !hit_wall;
    assign wall_over = !WRAP_EN && hit_wall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (start) begin
                    state_d = ST_RUN;
                end else if (tick && wall_over) begin
                    state_d = ST_OVER;
                end
            end
            ST_OVER: begin
                if (start) state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // tick is already masked by start, so a restart always beats a coincident step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q       <= X_MID;
            y_q       <= Y_MID;
            heading_q <= DIR_UP;
            pulse_q   <= 1'b0;
        end else begin
            pulse_q <= 1'b0;
            if (start) begin
                x_q       <= X_MID;
                y_q       <= Y_MID;
                heading_q <= DIR_UP;
            end else if (tick) begin
                heading_q <= step_dir;
                if (move_ok) begin
                    x_q     <= x_step;
                    y_q     <= y_step;
                    pulse_q <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        head_x     = x_q;
        head_y     = y_q;
        heading    = heading_q;
        move_pulse = pulse_q;
        game_over  = (state_q == ST_OVER);
    end

endmodule

// File: tb/tb_snake_head_step.sv
// Directed + randomized bench for snake_head_step on an 8x8 grid stepping every 4 cycles.
module tb_snake_head_step;

    localparam int W  = 8;
    localparam int H  = 8;
    localparam int TD = 4;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       pause;
    logic [1:0] direction;
    logic [2:0] head_x;
    logic [2:0] head_y;
    logic       move_pulse;
    logic       game_over;
    logic [1:0] heading;

    snake_head_step #(
        .GRID_W   (W),
        .GRID_H   (H),
        .TICK_DIV (TD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .pause      (pause),
        .direction  (direction),
        .head_x     (head_x),
        .head_y     (head_y),
        .move_pulse (move_pulse),
        .game_over  (game_over),
        .heading    (heading)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum {M_IDLE, M_RUN, M_OVER} mstate_e;

    mstate_e m_st;
    int      m_x, m_y, m_h, m_cnt;
    bit      m_pulse;
    int      DX[4];
    int      DY[4];

    int checks = 0;
    int passed = 0;

    task automatic model_reset();
        m_st    = M_IDLE;
        m_x     = W / 2;
        m_y     = H / 2;
        m_h     = 0;
        m_cnt   = 0;
        m_pulse = 0;
    endtask

    // Heading index: 0 up, 1 down, 2 right, 3 left; pairs {0,1} and {2,3} are opposites.
    task automatic model_step(input int d);
        int nx, ny;
        if ((d / 2 == m_h / 2) && (d != m_h)) d = m_h;
        m_h = d;
        nx  = m_x + DX[d];
        ny  = m_y + DY[d];
        if (nx >= 0 && nx < W && ny >= 0 && ny < H) begin
            m_x     = nx;
            m_y     = ny;
            m_pulse = 1;
        end else begin
`ifdef SNAKE_WRAP_EN
            m_x     = (nx + W) % W;
            m_y     = (ny + H) % H;
            m_pulse = 1;
`else
            m_st = M_OVER;
`endif
        end
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            model_reset();
            return;
        end
        m_pulse = 0;
        if (start) begin
            m_st  = M_RUN;
            m_x   = W / 2;
            m_y   = H / 2;
            m_h   = 0;
            m_cnt = 0;
        end else if (m_st == M_RUN && !pause) begin
            if (m_cnt < TD - 1) begin
                m_cnt++;
            end else begin
                m_cnt = 0;
                model_step(int'(direction));
            end
        end
    endtask

    task automatic chk(input string tag, input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s.%s: observed %0d expected %0d", tag, name, obs, exp);
    endtask

    task automatic check_all(input string tag);
        chk(tag, "head_x",     head_x,     m_x);
        chk(tag, "head_y",     head_y,     m_y);
        chk(tag, "heading",    heading,    m_h);
        chk(tag, "move_pulse", move_pulse, 32'(m_pulse));
        chk(tag, "game_over",  game_over,  32'(m_st == M_OVER));
    endtask

    task automatic cyc(input bit s, input bit p, input logic [1:0] d, input string tag);
        start     = s;
        pause     = p;
        direction = d;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic run_cycles(input int n, input bit p, input logic [1:0] d, input string tag);
        for (int i = 0; i < n; i++) cyc(1'b0, p, d, tag);
    endtask

    task automatic async_reset(input string tag);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all(tag);
    endtask

    initial begin
        DX[0] = 0;  DX[1] = 0; DX[2] = 1; DX[3] = -1;
        DY[0] = -1; DY[1] = 1; DY[2] = 0; DY[3] = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        pause     = 1'b0;
        direction = 2'b00;
        model_reset();

        run_cycles(3, 1'b0, 2'b10, "reset");
        rst_n = 1'b1;

        // No stepping before start, pause/direction ignored in IDLE.
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'(i % 2), 2'($urandom_range(0, 3)), "idle");

        // Walk right to the wall, then one more step into it.
        cyc(1'b1, 1'b0, 2'b10, "start");
        run_cycles(12, 1'b0, 2'b10, "walk_right");
        run_cycles(4, 1'b0, 2'b10, "wall");
        run_cycles(5, 1'b1, 2'($urandom_range(0, 3)), "hold");

        // Restart, then reversal rejection and a turn up.
        cyc(1'b1, 1'b0, 2'b11, "restart");
        run_cycles(4, 1'b0, 2'b10, "turn_right");
        run_cycles(4, 1'b0, 2'b11, "reverse_rej");
        run_cycles(4, 1'b0, 2'b00, "turn_up");

        // Pause mid-count.
        run_cycles(2, 1'b0, 2'b00, "pre_pause");
        run_cycles(10, 1'b1, 2'b00, "paused");
        run_cycles(4, 1'b0, 2'b00, "post_pause");

        // Restart has priority over a step on the same edge.
        run_cycles(3, 1'b0, 2'b10, "pre_prio");
        cyc(1'b1, 1'b0, 2'b10, "start_prio");

        // Asynchronous reset one cycle ahead of a step edge.
        run_cycles(3, 1'b0, 2'b10, "pre_rst");
        async_reset("rst_async");
        cyc(1'b0, 1'b0, 2'b10, "rst_hold");
        rst_n = 1'b1;
        run_cycles(8, 1'b0, 2'b10, "post_rst_idle");

        cyc(1'b1, 1'b0, 2'b01, "rand_start");
        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                async_reset("rand_rst");
                cyc(1'b0, 1'b0, 2'b00, "rand_rst_hold");
                rst_n = 1'b1;
            end
            cyc($urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0,
                2'($urandom_range(0, 3)), "rand");
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/snake_head_step.md
SNAKE_HEAD_STEP -- requirements
Module: snake_head_step

Interface
REQ-001 SHALL have parameter GRID_W, default 32, grid columns (>=2).
REQ-002 SHALL have parameter GRID_H, default 24, grid rows (>=2).
REQ-003 SHALL have parameter TICK_DIV, default 5_000_000, clk cycles per head step (>=2).
REQ-004 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1  level, begins or restarts a game.
REQ-007 SHALL have port pause  input  1  level, freezes stepping while high in RUN.
REQ-008 SHALL have port direction  input  2  requested heading: 00 up, 01 down, 10 right, 11 left.
REQ-009 SHALL have port head_x  output  $clog2(GRID_W)  head column, 0 = leftmost.
REQ-010 SHALL have port head_y  output  $clog2(GRID_H)  head row, 0 = top.
REQ-011 SHALL have port move_pulse  output  1  one-cycle strobe, head moved this cycle.
REQ-012 SHALL have port game_over  output  1  high while in OVER.
REQ-013 SHALL have port heading  output  2  heading applied on the last step, same encoding as direction.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, OVER.
REQ-015 IDLE: start=1 -> RUN; head to (GRID_W/2, GRID_H/2), heading 00, tick counter 0.
REQ-016 OVER: start=1 -> RUN with the same initialisation as REQ-015; otherwise hold all outputs.
REQ-017 RUN: tick counter increments each cycle with pause=0; holds with pause=1.
REQ-018 RUN: on the edge where counter==TICK_DIV-1 and pause=0, counter -> 0 and a step is taken; step period exactly TICK_DIV cycles.
REQ-019 Step heading SHALL be direction sampled at the step edge, except that the direct opposite of the current heading (00<->01, 10<->11) is rejected and the current heading kept.
REQ-020 Step: up y-1, down y+1, right x+1, left x-1; head, heading and move_pulse all update on the same edge; move_pulse high exactly one cycle.
REQ-021 start=1 in RUN SHALL reinitialise as in REQ-015 (restart); start takes priority over a coincident step.
REQ-022 pause SHALL be ignored in IDLE and OVER.
REQ-023 Wall behaviour per Configuration.

Reset
REQ-024 rst_n=0 SHALL immediately force IDLE, head (GRID_W/2, GRID_H/2), heading 00, counter 0, move_pulse 0, game_over 0, including mid-count or mid-step.
REQ-025 After rst_n release, no step occurs before start.

Configuration
REQ-026 Macro SNAKE_WRAP_EN defined: a step leaving the grid wraps (x GRID_W-1 right -> 0, x 0 left -> GRID_W-1, y likewise with GRID_H); OVER never entered from walls; move_pulse asserted.
REQ-027 Macro SNAKE_WRAP_EN undefined: a step leaving the grid does not move the head; FSM -> OVER, game_over=1 next cycle, move_pulse stays 0, heading updated to the offending heading.

Structure
REQ-028 Shared package snake_pkg SHALL hold the 2-bit direction typedef with constants DIR_UP/DIR_DOWN/DIR_RIGHT/DIR_LEFT, the FSM state typedef, and an opposite-direction function.
REQ-029 Tick divider SHALL be a sub-module snake_tick_gen (enable, clear, one-cycle tick out).

Verification (GRID_W=8, GRID_H=8, TICK_DIV=4)
REQ-030 Reset, start pulse, direction=10 -> move_pulse every 4 cycles; head (4,4)->(5,4)->(6,4)->(7,4).
REQ-031 Heading 10, drive direction=11 across a step -> heading stays 10, x increments; then 00 -> y decrements.
REQ-032 Head (7,4) heading 10, step, no SNAKE_WRAP_EN -> head holds (7,4), game_over=1, move_pulse=0; with SNAKE_WRAP_EN -> head (0,4), game_over=0.
REQ-033 pause=1 for 10 cycles mid-count -> no move_pulse; after release, next step exactly the remaining count later.
REQ-034 In OVER, start pulse -> head (4,4), heading 00, game_over=0, first move_pulse 4 cycles later.
REQ-035 rst_n low one cycle before a step edge -> outputs reset immediately, no move_pulse, FSM in IDLE.
